// File: rtl/bnn_seq_ctrl.sv
// bnn_seq_ctrl: frame sequencer for the BNN voice-activity datapath.
// Accepts a buffered MFCC frame, clears the MAC accumulators, steps the
// window index through NWIN windows, waits PIPE cycles for the scores to
// settle, compares the two class scores and holds the decision until the
// consumer takes it.
module bnn_seq_ctrl #(
  parameter int NWIN = 36,
  parameter int SW   = 10,
  parameter int PIPE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frm_valid,
  output logic          frm_ready,
  input  logic          abort,
  output logic [5:0]    win_idx,
  output logic          acc_clr,
  output logic          acc_en,
  input  logic [SW-1:0] score0,
  input  logic [SW-1:0] score1,
  output logic [1:0]    result,
  output logic          result_valid,
  input  logic          result_ready,
  output logic          busy,
  output logic [15:0]   frame_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, CMP, HOLD} state_t;

  // Last count value in RUN and DRAIN; the DRAIN value is unused when PIPE=0.
  localparam logic [15:0] RUN_LAST = 16'(NWIN - 1);
  localparam logic [15:0] DRN_LAST = (PIPE > 0) ? 16'(PIPE - 1) : 16'd0;
  // With no datapath pipeline the scores are already settled after RUN.
  localparam state_t      POST_RUN = (PIPE > 0) ? DRAIN : CMP;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  result_q, result_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // State, step counter, decision and delivered-frame count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      result_q    <= 2'b00;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state logic; the step counter is zero everywhere except while
  // stepping through RUN/DRAIN, so each phase starts counting from 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    result_d    = result_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE:  if (frm_valid) state_d = CLEAR;
      CLEAR: state_d = RUN;
      RUN: begin
        if (cnt_q == RUN_LAST) state_d = POST_RUN;
        else                   cnt_d   = cnt_q + 16'd1;
      end
      DRAIN: begin
        if (cnt_q == DRN_LAST) state_d = CMP;
        else                   cnt_d   = cnt_q + 16'd1;
      end
      CMP: begin
        result_d = ($signed(score1) >= $signed(score0)) ? 2'b10 : 2'b01;
        state_d  = HOLD;
      end
      HOLD: begin
        if (result_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything, including a same-cycle handshake; the
    // previous decision and the count are left untouched.
    if (abort && state_q != IDLE) begin
      state_d     = IDLE;
      cnt_d       = '0;
      result_d    = result_q;
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Outputs decode straight from the state so reset clears them at once.
  assign frm_ready    = (state_q == IDLE);
  assign acc_clr      = (state_q == CLEAR);
  assign acc_en       = (state_q == RUN);
  assign win_idx      = acc_en ? cnt_q[5:0] : 6'd0;
  assign result_valid = (state_q == HOLD);
  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Directed bench for bnn_seq_ctrl at default parameters.
module tb_bnn_seq_ctrl;

  localparam int NWIN = 36;
  localparam int SW   = 10;
  localparam int PIPE = 1;
  localparam int LAT  = 1 + NWIN + PIPE + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frm_valid, frm_ready, abort;
  logic [5:0]    win_idx;
  logic          acc_clr, acc_en;
  logic [SW-1:0] score0, score1;
  logic [1:0]    result;
  logic          result_valid, result_ready, busy;
  logic [15:0]   frame_cnt;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt;
  logic [1:0]  exp_res;

  bnn_seq_ctrl #(.NWIN(NWIN), .SW(SW), .PIPE(PIPE)) dut (
    .clk(clk), .rst_n(rst_n), .frm_valid(frm_valid), .frm_ready(frm_ready),
    .abort(abort), .win_idx(win_idx), .acc_clr(acc_clr), .acc_en(acc_en),
    .score0(score0), .score1(score1), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [SW-1:0] s1;
    logic signed [SW-1:0] s0;
    logic [1:0]           res;
    int                   hold;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Launch a frame and step until result_valid; checks the RUN phase.
  task automatic to_valid(input logic signed [SW-1:0] s1,
                          input logic signed [SW-1:0] s0,
                          input logic rdy);
    int lat, n_en, n_clr, bad_idx;
    score1 = s1; score0 = s0; result_ready = rdy; frm_valid = 1'b1;
    chk("frm_ready_idle", int'(frm_ready), 1);
    lat = -1; n_en = 0; n_clr = 0; bad_idx = 0;
    for (int n = 1; n <= 200 && lat < 0; n++) begin
      @(negedge clk);
      frm_valid = 1'b0;
      if (acc_clr) n_clr++;
      if (acc_en) begin
        if (win_idx != n_en[5:0]) bad_idx++;
        n_en++;
      end
      if (result_valid) lat = n - 1;
    end
    chk("latency", lat, LAT);
    chk("acc_en_cycles", n_en, NWIN);
    chk("win_idx_seq_errs", bad_idx, 0);
    chk("acc_clr_cycles", n_clr, 1);
  endtask

  // Full frame with optional backpressure of hold cycles before handshake.
  task automatic do_frame(input logic signed [SW-1:0] s1,
                          input logic signed [SW-1:0] s0,
                          input logic [1:0] er, input int hold);
    to_valid(s1, s0, hold == 0);
    chk("result", int'(result), int'(er));
    for (int k = 0; k < hold; k++) begin
      frm_valid = 1'b1;
      @(negedge clk);
      chk("bp_valid", int'(result_valid), 1);
      chk("bp_result", int'(result), int'(er));
      chk("bp_frm_ready", int'(frm_ready), 0);
    end
    frm_valid = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk("post_valid", int'(result_valid), 0);
    chk("post_frm_ready", int'(frm_ready), 1);
    chk("post_busy", int'(busy), 0);
    chk("frame_cnt", int'(frame_cnt), int'(exp_cnt));
    chk("result_persist", int'(result), int'(er));
  endtask

  // Step a running frame until win_idx reaches the target, bounded.
  task automatic run_to_idx(input int idx);
    int ok;
    score1 = 10'sd1; score0 = 10'sd0; result_ready = 1'b1; frm_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 100 && ok == 0; n++) begin
      @(negedge clk);
      frm_valid = 1'b0;
      if (acc_en && win_idx == idx[5:0]) ok = 1;
    end
    chk("reach_win_idx", ok, 1);
  endtask

  initial begin
    tbl[0] = '{s1:  10'sd5,   s0:  10'sd3,   res: 2'b10, hold: 0};
    tbl[1] = '{s1: -10'sd4,   s0: -10'sd4,   res: 2'b10, hold: 0};
    tbl[2] = '{s1: -10'sd5,   s0:  10'sd2,   res: 2'b01, hold: 0};
    tbl[3] = '{s1: -10'sd512, s0:  10'sd511, res: 2'b01, hold: 0};
    tbl[4] = '{s1:  10'sd511, s0: -10'sd512, res: 2'b10, hold: 10};
    tbl[5] = '{s1:  10'sd0,   s0:  10'sd1,   res: 2'b01, hold: 0};

    rst_n = 1'b0; frm_valid = 1'b0; abort = 1'b0; result_ready = 1'b0;
    score0 = '0; score1 = '0; exp_cnt = 16'd0;
    #1;
    chk("rst_result", int'(result), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_acc_en", int'(acc_en), 0);
    chk("rst_acc_clr", int'(acc_clr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("frm_ready_after_rst", int'(frm_ready), 1);

    for (int i = 0; i < 6; i++) do_frame(tbl[i].s1, tbl[i].s0, tbl[i].res, tbl[i].hold);
    exp_res = tbl[5].res;

    // Abort mid-RUN at window 17, then a clean frame.
    run_to_idx(17);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_acc_en", int'(acc_en), 0);
    chk("abort_win_idx", int'(win_idx), 0);
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (result_valid) chk("abort_no_valid", 1, 0);
    end
    chk("abort_frame_cnt", int'(frame_cnt), int'(exp_cnt));
    chk("abort_result_kept", int'(result), int'(exp_res));
    do_frame(10'sd7, 10'sd9, 2'b01, 0);

    // Abort in IDLE is ignored and frm_valid is taken; abort then flushes CLEAR.
    abort = 1'b1; frm_valid = 1'b1;
    @(negedge clk);
    frm_valid = 1'b0;
    chk("idle_abort_accepts", int'(acc_clr), 1);
    @(negedge clk);
    abort = 1'b0;
    chk("clear_abort_idle", int'(busy), 0);

    // Abort beats a same-cycle handshake in HOLD.
    to_valid(10'sd3, 10'sd3, 1'b0);
    abort = 1'b1; result_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; result_ready = 1'b0;
    chk("hold_abort_valid", int'(result_valid), 0);
    chk("hold_abort_cnt", int'(frame_cnt), int'(exp_cnt));

    // Asynchronous reset in RUN at window 20.
    run_to_idx(20);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_acc_en", int'(acc_en), 0);
    chk("arst_win_idx", int'(win_idx), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_result", int'(result), 0);
    chk("arst_frame_cnt", int'(frame_cnt), 0);
    chk("arst_valid", int'(result_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 16'd0;
    @(negedge clk);
    chk("arst_frm_ready", int'(frm_ready), 1);
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (result_valid || busy) chk("arst_no_frame", 1, 0);
    end
    do_frame(-10'sd1, -10'sd2, 2'b10, 0);

    // Counter wrap: preload to all-ones, next delivery wraps to zero.
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    chk("preload_cnt", int'(frame_cnt), 16'hFFFF);
    exp_cnt = 16'hFFFF;
    do_frame(10'sd2, 10'sd1, 2'b10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
